// File: rtl/alu_divider_pkg.sv
// Shared constants for the iterative divider: default operand width,
// iteration counter width and FSM state encodings.
package alu_divider_pkg;

  localparam int LEN_DATA_DEF = 64;
  localparam int CNT_W        = 6;
  localparam int STATE_W      = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
  localparam logic [STATE_W-1:0] ST_FIX  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/alu_divider_div_step.sv
// One radix-2 non-restoring division step on unsigned magnitudes.
// The partial remainder is kept two bits wider than the operands so that
// the shifted value (range -2D..2D) never overflows.
module div_step
  import alu_divider_pkg::*;
#(
  parameter int LEN_DATA = LEN_DATA_DEF
) (
  input  logic signed [LEN_DATA+1:0] rem_in,
  input  logic        [LEN_DATA-1:0] divisor,
  input  logic        [LEN_DATA-1:0] quo_in,
  output logic signed [LEN_DATA+1:0] rem_out,
  output logic        [LEN_DATA-1:0] quo_out
);

  logic signed [LEN_DATA+1:0] shifted;
  logic signed [LEN_DATA+1:0] div_ext;

  // Shift in the next dividend bit, then subtract or add the divisor
  // depending on the sign of the current partial remainder.
  always_comb begin
    shifted = {rem_in[LEN_DATA:0], quo_in[LEN_DATA-1]};
    div_ext = $signed({2'b00, divisor});
    if (rem_in[LEN_DATA+1]) begin
      rem_out = shifted + div_ext;
    end else begin
      rem_out = shifted - div_ext;
    end
    quo_out = {quo_in[LEN_DATA-2:0], ~rem_out[LEN_DATA+1]};
  end

endmodule

// File: rtl/alu_divider.sv
// Iterative signed/unsigned divider. Operands are reduced to magnitudes on
// accept, one non-restoring step runs per CALC cycle, and FIX corrects the
// remainder and applies the result signs before the result is presented.
module alu_divider
  import alu_divider_pkg::*;
#(
  parameter int LEN_DATA = LEN_DATA_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                signed_op,
  input  logic [LEN_DATA-1:0] dividend,
  input  logic [LEN_DATA-1:0] divisor,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] quotient,
  output logic [LEN_DATA-1:0] remainder,
  output logic                div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN_DATA - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [STATE_W-1:0]         state;
  logic [CNT_W-1:0]           cnt;

  logic signed [LEN_DATA+1:0] rem_p;
  logic        [LEN_DATA-1:0] quo_p;
  logic        [LEN_DATA-1:0] div_mag;
  logic                       neg_q;
  logic                       neg_r;

  logic signed [LEN_DATA+1:0] rem_next;
  logic        [LEN_DATA-1:0] quo_next;

  logic                       accept;
  logic                       div_zero;
  logic                       dvd_neg;
  logic                       dvs_neg;
  logic        [LEN_DATA-1:0] rem_low;
  logic        [LEN_DATA-1:0] fix_q;
  logic        [LEN_DATA-1:0] fix_r;

  // Two's-complement negate when requested; used both to form magnitudes
  // and to restore the signs of the results.
  function automatic logic [LEN_DATA-1:0] apply_sign(input logic [LEN_DATA-1:0] v,
                                                     input logic               neg);
    return neg ? (~v + LEN_DATA'(1)) : v;
  endfunction

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = (state == ST_IDLE) && in_valid && !flush;
  assign div_zero  = (divisor == '0);
  assign dvd_neg   = signed_op && dividend[LEN_DATA-1];
  assign dvs_neg   = signed_op && divisor[LEN_DATA-1];

  // The true remainder is in [0, D), so the low bits alone carry the
  // corrected value after adding the divisor back to a negative remainder.
  assign rem_low = rem_p[LEN_DATA-1:0] + (rem_p[LEN_DATA+1] ? div_mag : '0);
  assign fix_q   = apply_sign(quo_p, neg_q);
  assign fix_r   = apply_sign(rem_low, neg_r);

  div_step #(
    .LEN_DATA (LEN_DATA)
  ) u_div_step (
    .rem_in  (rem_p),
    .divisor (div_mag),
    .quo_in  (quo_p),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  // Working datapath: load magnitudes on accept, iterate while in CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_p   <= '0;
      quo_p   <= apply_sign(dividend, dvd_neg);
      div_mag <= apply_sign(divisor, dvs_neg);
      neg_q   <= dvd_neg ^ dvs_neg;
      neg_r   <= dvd_neg;
    end else if (state == ST_CALC) begin
      rem_p   <= rem_next;
      quo_p   <= quo_next;
    end
  end

  // FSM, iteration counter and result registers; flush overrides everything
  // and leaves the previous result untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cnt <= '0;
            if (div_zero) begin
              state       <= ST_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (cnt == CNT_LAST) begin
            state <= ST_FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_FIX: begin
          state       <= ST_DONE;
          quotient    <= fix_q;
          remainder   <= fix_r;
          div_by_zero <= 1'b0;
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Randomized self-checking bench for alu_divider against a plain-arithmetic
// reference model, plus directed corner cases and abort scenarios.
module tb_alu_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: division semantics straight from the rules, using native
  // 64-bit arithmetic (truncating signed division, remainder follows dividend).
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    z = 1'b0;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (s && a == MIN_NEG && b == '1) begin
      q = MIN_NEG;
      r = '0;
    end else if (s) begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Issue one operation, measure latency, compare result, hold it for
  // 'hold' cycles with out_ready low, then consume it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    logic         busy_ready;
    model(a, b, s, eq, er, ez);
    @(negedge clk);
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid  = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
    lat        = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", W'(lat), (b == '0) ? W'(1) : W'(W + 2));
    check("busy_in_ready", W'(busy_ready), W'(0));
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", W'(div_by_zero), W'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", W'(out_valid), W'(1));
      check("hold_ready", W'(in_ready), W'(0));
      check("hold_q", quotient, eq);
      check("hold_r", remainder, er);
      check("hold_z", W'(div_by_zero), W'(ez));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("taken_valid", W'(out_valid), W'(0));
    check("taken_ready", W'(in_ready), W'(1));
    out_ready = 1'b0;
  endtask

  // Accept 100/7 and let it run until the counter reaches 30.
  task automatic start_and_wait30();
    @(negedge clk);
    in_valid  = 1'b1;
    signed_op = 1'b0;
    dividend  = 64'd100;
    divisor   = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("calc_busy", W'(in_ready), W'(0));
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           mode;

    rst       = 1'b1;
    in_valid  = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", W'(div_by_zero), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(64'd100, 64'd7, 1'b0, 1);
    run_op(-64'sd7, 64'd2, 1'b1, 0);
    run_op(64'd7, -64'sd2, 1'b1, 0);
    run_op(64'd5, 64'd0, 1'b0, 2);
    run_op(MIN_NEG, '1, 1'b1, 0);
    run_op(64'hDEAD_BEEF_0000_1234, 64'd3, 1'b0, 10);
    run_op('1, 64'd1, 1'b0, 0);
    run_op(-64'sd9, -64'sd4, 1'b1, 0);

    // Asynchronous reset in the middle of CALC
    start_and_wait30();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", W'(in_ready), W'(1));
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_quotient", quotient, '0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd100, 64'd7, 1'b0, 0);

    // Flush in the middle of CALC keeps the previous result
    start_and_wait30();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", W'(in_ready), W'(1));
    check("flush_out_valid", W'(out_valid), W'(0));
    repeat (3) @(posedge clk);
    #1;
    check("flush_idle_valid", W'(out_valid), W'(0));
    check("flush_hold_q", quotient, 64'd14);
    run_op(64'd100, 64'd7, 1'b0, 0);

    // Flush together with in_valid in IDLE must not accept
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    signed_op = 1'b0;
    dividend  = 64'd5;
    divisor   = 64'd0;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_accept_valid", W'(out_valid), W'(0));
    check("flush_accept_ready", W'(in_ready), W'(1));
    check("flush_accept_dbz", W'(div_by_zero), W'(0));

    // Randomized operations
    for (int k = 0; k < 30; k++) begin
      mode = $urandom_range(0, 7);
      s    = 1'($urandom_range(0, 1));
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      case (mode)
        0: b = '0;
        1: begin
          b = W'($urandom_range(1, 20));
          if (s && $urandom_range(0, 1) == 1) b = -b;
        end
        2: begin
          s = 1'b1;
          a = MIN_NEG;
          b = '1;
        end
        3: b = b >> $urandom_range(1, 62);
        default: ;
      endcase
      run_op(a, b, s, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 The module SHALL have the parameter LEN_DATA, default `LEN_DATA (64) from the shared define file, giving the operand width.
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  unit can accept operands (high only in IDLE).
REQ-006 signed_op  input  1  1 means two's-complement division, 0 means unsigned division.
REQ-007 dividend  input  LEN_DATA  numerator.
REQ-008 divisor  input  LEN_DATA  denominator.
REQ-009 flush  input  1  synchronous abort of any operation in flight.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 quotient  output  LEN_DATA  quotient result.
REQ-013 remainder  output  LEN_DATA  remainder result.
REQ-014 div_by_zero  output  1  set when the accepted divisor was zero.

Function
REQ-015 Operands SHALL be accepted on a rising edge where in_valid && in_ready is true; these are the only edges on which operands are sampled.
REQ-016 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-017 FSM transitions SHALL be: IDLE->CALC on accept with nonzero divisor; IDLE->DONE on accept with zero divisor; CALC->FIX after LEN_DATA iterations; FIX->DONE; DONE->IDLE when out_ready is high.
REQ-018 CALC SHALL perform one radix-2 non-restoring step per cycle on the operand magnitudes, using a 6-bit iteration counter that counts 0..LEN_DATA-1.
REQ-019 FIX SHALL add the divisor back to a negative partial remainder, then apply the signs for signed_op: the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-020 Latency SHALL be LEN_DATA+2 cycles from the accept edge to out_valid high (66 cycles at 64 bits); for a zero divisor, the latency SHALL be 1 cycle.
REQ-021 For a zero divisor, the result SHALL be quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-022 For a signed divide of the most negative value by -1, the result SHALL be quotient = the most negative value, remainder = 0, div_by_zero = 0.
REQ-023 While out_valid is high and out_ready is low, quotient, remainder and div_by_zero SHALL stay stable.
REQ-024 in_ready SHALL be low in CALC, FIX and DONE; no new operation may overlap a result that has not been taken.
REQ-025 flush SHALL move the FSM to IDLE on the next edge from any state and discard the result; if flush and in_valid are high on the same IDLE edge, the operands SHALL NOT be accepted.
REQ-026 Outside DONE, out_valid SHALL be low; quotient, remainder and div_by_zero SHALL hold their last values.

Reset
REQ-027 Asserting rst SHALL, asynchronously and from any state, set state = IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0 and the counter = 0.
REQ-028 After rst is released, the first accept SHALL be possible on the first rising edge.

Structure
REQ-029 LEN_DATA and the state encodings SHALL live in the shared define file; no literal widths are allowed in the module.
REQ-030 The single non-restoring iteration SHALL be one sub-module, div_step, which is combinational and takes the partial remainder, the divisor and the quotient bits and returns their next values; alu_divider instantiates it once.
REQ-031 The design SHALL contain only one sequential register set (FSM state, counter, operand and result registers), and it SHALL be clocked by clk only.

Verification
REQ-032 Unsigned 100 / 7 -> after 66 cycles out_valid = 1, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-033 Signed -7 / 2 -> quotient = -3, remainder = -1; signed 7 / -2 -> quotient = -3, remainder = 1.
REQ-034 Unsigned 5 / 0 -> on the next cycle out_valid = 1, quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 5, div_by_zero = 1.
REQ-035 Signed 0x8000_0000_0000_0000 / -1 -> quotient = 0x8000_0000_0000_0000, remainder = 0.
REQ-036 Hold out_ready low for 10 cycles in DONE -> outputs stable and in_ready = 0; raise out_ready -> in the next cycle out_valid = 0 and in_ready = 1.
REQ-037 Assert rst at CALC iteration 30, and separately assert flush at iteration 30 -> IDLE, in_ready = 1, out_valid = 0, and a following 100 / 7 gives the correct result.
